// File: rtl/modacc.sv
// modacc: streaming modular accumulator, one sum mod q per frame.
// The modulus has the sparse form q = {qH, zeros, 1'b1} and is latched from
// qH on the first beat of each frame.
// Optional feature macro: MODACC_NEG_EN adds the in_neg port and a modular
// subtract path. With it undefined the block only adds.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         input beat handshake
//   in_data, in_last          residue (< q) and end-of-frame marker
//   in_neg                    subtract the beat (MODACC_NEG_EN only)
//   qH                        modulus high part
//   out_valid/out_ready       result handshake
//   out_data, out_count       frame sum mod q and saturating beat count
module modacc #(
  parameter int unsigned LOGQ  = 64,
  parameter int unsigned LOGQH = 47,
  parameter int unsigned LOGN  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  in_data,
  input  logic             in_last,
`ifdef MODACC_NEG_EN
  input  logic             in_neg,
`endif
  input  logic [LOGQH-1:0] qH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  out_data,
  output logic [LOGN-1:0]  out_count
);

  localparam int unsigned ZW = LOGQ - LOGQH - 1;

  typedef enum logic {S_ACC = 1'b0, S_HOLD = 1'b1} state_t;

  state_t          state, state_n;
  logic [LOGQ-1:0] acc;
  logic [LOGN-1:0] cnt;
  logic [LOGQ-1:0] q_r;
  logic            first;

  logic            accept;
  logic [LOGQ-1:0] q_new, q_use;
  logic [LOGQ:0]   s, t;
  logic [LOGQ-1:0] add_res, res;
  logic [LOGN-1:0] cnt_inc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACC;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_ACC:   if (accept && in_last) state_n = S_HOLD;
      S_HOLD:  if (out_ready)         state_n = S_ACC;
      default: state_n = S_ACC;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_ACC:   in_ready  = 1'b1;
      S_HOLD:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready;

  // First beat of a frame uses the live qH; later beats use the latched q
  assign q_new = {qH, ZW'(0), 1'b1};
  assign q_use = first ? q_new : q_r;

  // Modular add: keep s - q when it does not borrow
  assign s       = {1'b0, acc} + {1'b0, in_data};
  assign t       = s - {1'b0, q_use};
  assign add_res = t[LOGQ] ? s[LOGQ-1:0] : t[LOGQ-1:0];

`ifdef MODACC_NEG_EN
  logic [LOGQ:0]   d;
  logic [LOGQ-1:0] sub_res;

  // Modular subtract: add q back when acc - in_data borrows
  assign d       = {1'b0, acc} - {1'b0, in_data};
  assign sub_res = d[LOGQ] ? (d[LOGQ-1:0] + q_use) : d[LOGQ-1:0];
  assign res     = in_neg ? sub_res : add_res;
`else
  assign res     = add_res;
`endif

  assign cnt_inc = (cnt == {LOGN{1'b1}}) ? cnt : cnt + LOGN'(1);

  // Accumulator, counter, modulus latch and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      q_r       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_count <= '0;
    end else if (accept) begin
      acc   <= res;
      cnt   <= cnt_inc;
      first <= 1'b0;
      if (first) q_r <= q_new;
      if (in_last) begin
        out_data  <= res;
        out_count <= cnt_inc;
      end
    end else if (state == S_HOLD && out_ready) begin
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b1;
    end
  end

endmodule

// File: tb/tb_modacc.sv
// tb_modacc: directed bench for modacc with a reference model of frame sums.
module tb_modacc;

  localparam logic [46:0] QH = 47'h400008C00000;
  localparam logic [63:0] Q  = 64'h8000118000000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
`ifdef MODACC_NEG_EN
  logic        in_neg;
`endif
  logic [46:0] qH;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] out_count;

  int n_chk  = 0;
  int n_pass = 0;

  modacc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef MODACC_NEG_EN
    .in_neg    (in_neg),
`endif
    .qH        (qH),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: frame sums by plain modular arithmetic
  logic        m_hold;
  logic        m_first;
  logic [65:0] m_acc;
  logic [65:0] m_q;
  int          m_cnt;
  logic [63:0] m_out;
  int          m_outcnt;

  always @(posedge clk or posedge rst) begin
    logic [65:0] qq;
    logic        neg;
    if (rst) begin
      m_hold = 1'b0; m_first = 1'b1; m_acc = '0; m_q = '0;
      m_cnt = 0; m_out = '0; m_outcnt = 0;
    end else if (!m_hold) begin
      if (in_valid) begin
        qq = m_first ? 66'(QH) * 66'(131072) + 66'd1 : m_q;
        qq = m_first ? 66'({qH, 16'h0, 1'b1}) : m_q;
        if (m_first) m_q = qq;
        m_first = 1'b0;
        neg = 1'b0;
`ifdef MODACC_NEG_EN
        neg = in_neg;
`endif
        if (neg) m_acc = (m_acc + qq - 66'(in_data)) % qq;
        else     m_acc = (m_acc + 66'(in_data)) % qq;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (in_last) begin
          m_out = m_acc[63:0]; m_outcnt = m_cnt; m_hold = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0; m_acc = '0; m_cnt = 0; m_first = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  64'(in_ready),  64'(!m_hold));
      chk("out_valid", 64'(out_valid), 64'(m_hold));
      chk("out_data",  out_data,       m_out);
      chk("out_count", 64'(out_count), 64'(m_outcnt));
    end
  end

  task automatic beat(input logic [63:0] d, input logic last, input logic neg);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
`ifdef MODACC_NEG_EN
    in_neg   = neg;
`else
    if (neg) $display("neg beat ignored in add-only build");
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk("wait_out_valid", 64'(seen), 64'd1);
  endtask

  task automatic frame_result(input string name, input logic [63:0] d, input logic [15:0] c);
    wait_valid();
    chk({name, "_data"},  out_data,        d);
    chk({name, "_count"}, 64'(out_count), 64'(c));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
`ifdef MODACC_NEG_EN
    in_neg = 1'b0;
`endif
    qH = QH; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    #2 rst = 1'b0;

    // Single-beat frame
    beat(64'h5, 1'b1, 1'b0);
    frame_result("single", 64'h5, 16'd1);
    @(negedge clk);
    chk("single_ready_back", 64'(in_ready), 64'd1);

    // Two-beat frame that wraps past q
    beat(64'h7000000000000000, 1'b0, 1'b0);
    beat(64'h2000000000000000, 1'b1, 1'b0);
    frame_result("wrap", 64'h0FFFEE7FFFFFFFFF, 16'd2);
    @(negedge clk);

    // Back-pressure: result held, beats refused
    out_ready = 1'b0;
    beat(64'h7000000000000000, 1'b0, 1'b0);
    beat(64'h2000000000000000, 1'b1, 1'b0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data",  out_data,       64'h0FFFEE7FFFFFFFFF);
      chk("hold_ready", 64'(in_ready),  64'd0);
      in_valid = 1'b1; in_data = 64'hDEAD; in_last = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    beat(64'h4, 1'b0, 1'b0);
    beat(64'h6, 1'b1, 1'b0);
    frame_result("after_hold", 64'hA, 16'd2);

    // qH changes mid-frame are ignored
    beat(64'h7000000000000000, 1'b0, 1'b0);
    qH = '0;
    beat(64'h2000000000000000, 1'b1, 1'b0);
    frame_result("qh_mid", 64'h0FFFEE7FFFFFFFFF, 16'd2);
    qH = QH;

    // Sums landing exactly on q and on 2q-2
    beat(Q - 64'd1, 1'b0, 1'b0);
    beat(64'd1, 1'b1, 1'b0);
    frame_result("eq_q", 64'd0, 16'd2);
    beat(Q - 64'd1, 1'b0, 1'b0);
    beat(Q - 64'd1, 1'b1, 1'b0);
    frame_result("two_qm1", Q - 64'd2, 16'd2);

    // Reset mid-frame discards the partial sum
    beat(64'd11, 1'b0, 1'b0);
    beat(64'd22, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    beat(64'd1, 1'b0, 1'b0);
    beat(64'd2, 1'b1, 1'b0);
    frame_result("after_rst", 64'd3, 16'd2);

`ifdef MODACC_NEG_EN
    beat(64'd3, 1'b0, 1'b0);
    beat(64'd5, 1'b1, 1'b1);
    frame_result("neg", 64'h8000117FFFFFFFFF, 16'd2);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
